// File: rtl/n_divide_ctrl.sv
// -----------------------------------------------------------------------------
// n_divide_ctrl
//
// Sequencer for the PLL feedback divider. Accepts a target divide ratio over a
// valid/ready handshake and walks the divider ratio toward it one step (+/-1)
// at a time. A new ratio is only loaded on the divider's terminal-count pulse,
// so the feedback clock never sees a truncated period. After every step the
// block waits SETTLE_CYCLES cycles to let the loop re-settle.
//
// Runs entirely in the divider clock domain (clk_out).
//
// Ports:
//   clk_out    in   1    divider clock, all logic on its rising edge
//   rst_n      in   1    asynchronous active-low reset
//   req_valid  in   1    target ratio request present
//   req_ready  out  1    request can be accepted (IDLE only)
//   req_n      in   N_W  target ratio
//   abort      in   1    stop the ramp, hold the current ratio
//   div_tc     in   1    one-cycle terminal-count pulse from the divider
//   div_n      out  N_W  registered ratio driven to the divider
//   div_load   out  1    one-cycle strobe, high while div_n shows a new value
//   busy       out  1    ramp in progress
//   done       out  1    one-cycle pulse, target reached and settled
//   err        out  1    sticky, last request was below N_MIN
//
// States:
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | waiting for a request, req_ready=1
//   S_WAIT_TC | ramp active, waiting for div_tc to apply the next step
//   S_SETTLE  | step applied, counting SETTLE_CYCLES before the next one
// -----------------------------------------------------------------------------
module n_divide_ctrl #(
    parameter int N_W           = 8,
    parameter int N_MIN         = 2,
    parameter int N_RESET       = 8,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic           clk_out,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [N_W-1:0] req_n,
    input  logic           abort,
    input  logic           div_tc,
    output logic [N_W-1:0] div_n,
    output logic           div_load,
    output logic           busy,
    output logic           done,
    output logic           err
);

    // A single-cycle settle still needs a one-bit counter to exist.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_W-1:0]   N_MIN_V   = N_W'(N_MIN);
    localparam logic [N_W-1:0]   N_RESET_V = N_W'(N_RESET);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_TC = 2'd1,
        S_SETTLE  = 2'd2
    } state_t;

    state_t           state,      state_nxt;
    logic [N_W-1:0]   target,     target_nxt;
    logic [N_W-1:0]   div_n_nxt;
    logic [CNT_W-1:0] settle_cnt, settle_cnt_nxt;
    logic             load_nxt;
    logic             done_nxt;
    logic             err_nxt;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            target     <= N_RESET_V;
            div_n      <= N_RESET_V;
            settle_cnt <= '0;
            div_load   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            target     <= target_nxt;
            div_n      <= div_n_nxt;
            settle_cnt <= settle_cnt_nxt;
            div_load   <= load_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        target_nxt     = target;
        div_n_nxt      = div_n;
        settle_cnt_nxt = settle_cnt;
        load_nxt       = 1'b0;
        done_nxt       = 1'b0;
        err_nxt        = err;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_n < N_MIN_V) begin
                        err_nxt = 1'b1;
                    end else if (req_n == div_n) begin
                        err_nxt  = 1'b0;
                        done_nxt = 1'b1;
                    end else begin
                        target_nxt = req_n;
                        err_nxt    = 1'b0;
                        state_nxt  = S_WAIT_TC;
                    end
                end
            end

            S_WAIT_TC: begin
                // abort has priority over a coincident terminal count
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (div_tc) begin
                    // target != div_n here, so the step never crosses target
                    if (target > div_n) begin
                        div_n_nxt = div_n + 1'b1;
                    end else begin
                        div_n_nxt = div_n - 1'b1;
                    end
                    load_nxt       = 1'b1;
                    settle_cnt_nxt = CNT_LOAD;
                    state_nxt      = S_SETTLE;
                end
            end

            S_SETTLE: begin
                // The load cycle is the first settle cycle (count = SETTLE-1),
                // so SETTLE spans exactly SETTLE_CYCLES cycles.
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (settle_cnt == '0) begin
                    if (div_n == target) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_WAIT_TC;
                    end
                end else begin
                    settle_cnt_nxt = settle_cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_n_divide_ctrl.sv
// -----------------------------------------------------------------------------
// tb_n_divide_ctrl
//
// Directed bench for n_divide_ctrl with SETTLE_CYCLES=4. A behavioural divider
// raises div_tc once every div_n cycles. A table of requests drives the main
// ramps; hand-written sequences cover abort, busy-time requests and reset.
// -----------------------------------------------------------------------------
module tb_n_divide_ctrl;

    localparam int N_W    = 8;
    localparam int SETTLE = 4;

    logic           clk_out;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [N_W-1:0] req_n;
    logic           abort;
    logic           div_tc;
    logic [N_W-1:0] div_n;
    logic           div_load;
    logic           busy;
    logic           done;
    logic           err;

    logic tc_gen;
    logic tc_force;
    logic tc_auto;
    int   tc_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [N_W-1:0] n;
        int             steps;
        logic [N_W-1:0] fin;
        logic           exp_err;
        int             exp_done;
    } vec_t;

    vec_t vecs[9];

    assign div_tc = tc_gen | tc_force;

    n_divide_ctrl #(
        .N_W          (8),
        .N_MIN        (2),
        .N_RESET      (8),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk_out  (clk_out),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_n    (req_n),
        .abort    (abort),
        .div_tc   (div_tc),
        .div_n    (div_n),
        .div_load (div_load),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial begin
        clk_out = 1'b0;
        forever #5 clk_out = ~clk_out;
    end

    // Behavioural divider: one terminal-count pulse every div_n cycles.
    initial begin
        tc_gen = 1'b0;
        tc_cnt = 0;
        forever begin
            @(posedge clk_out);
            #1;
            if (!tc_auto || !rst_n) begin
                tc_gen = 1'b0;
                tc_cnt = 0;
            end else if (tc_cnt >= int'(div_n) - 1) begin
                tc_gen = 1'b1;
                tc_cnt = 0;
            end else begin
                tc_gen = 1'b0;
                tc_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (req_ready !== 1'b1 && w < 100) begin
            @(negedge clk_out);
            w++;
        end
        check(name, req_ready, 1);
    endtask

    // Issue one request and follow it to completion, checking every step.
    task automatic run_req(input vec_t v, input int idx);
        int             loads, dones, last_load;
        logic [N_W-1:0] exp_n;
        logic           prev_tc;
        wait_ready($sformatf("v%0d_ready", idx));
        exp_n     = div_n;
        req_n     = v.n;
        req_valid = 1'b1;
        prev_tc   = div_tc;
        loads     = 0;
        dones     = 0;
        last_load = 0;
        @(negedge clk_out);
        req_valid = 1'b0;
        check($sformatf("v%0d_busy", idx), busy, (v.steps > 0) ? 1 : 0);
        check($sformatf("v%0d_err", idx), err, v.exp_err);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (cyc > 1) @(negedge clk_out);
            if (div_load === 1'b1) begin
                loads++;
                exp_n = (v.n > exp_n) ? exp_n + 1'b1 : exp_n - 1'b1;
                check($sformatf("v%0d_load%0d_n", idx, loads), div_n, exp_n);
                check($sformatf("v%0d_load%0d_after_tc", idx, loads), prev_tc, 1);
                if (loads > 1)
                    check($sformatf("v%0d_load%0d_spacing_ge5", idx, loads),
                          (cyc - last_load >= SETTLE + 1) ? 1 : 0, 1);
                last_load = cyc;
            end
            if (done === 1'b1) begin
                dones++;
                if (v.steps > 0)
                    check($sformatf("v%0d_done_gap", idx), cyc - last_load, SETTLE);
                else
                    check($sformatf("v%0d_done_cycle", idx), cyc, 1);
                check($sformatf("v%0d_done_ready", idx), req_ready, 1);
                check($sformatf("v%0d_done_busy", idx), busy, 0);
            end
            prev_tc = div_tc;
            if (dones > 0 || (v.exp_done == 0 && cyc >= 8)) break;
        end
        check($sformatf("v%0d_done_count", idx), dones, v.exp_done);
        check($sformatf("v%0d_load_count", idx), loads, v.steps);
        check($sformatf("v%0d_final_n", idx), div_n, v.fin);
        check($sformatf("v%0d_err_final", idx), err, v.exp_err);
        @(negedge clk_out);
        check($sformatf("v%0d_done_width", idx), done, 0);
    endtask

    initial begin
        int   w, nload, ndone;
        vec_t hv;

        vecs[0] = '{n: 8'd11, steps: 3, fin: 8'd11, exp_err: 1'b0, exp_done: 1};
        vecs[1] = '{n: 8'd8,  steps: 3, fin: 8'd8,  exp_err: 1'b0, exp_done: 1};
        vecs[2] = '{n: 8'd2,  steps: 6, fin: 8'd2,  exp_err: 1'b0, exp_done: 1};
        vecs[3] = '{n: 8'd1,  steps: 0, fin: 8'd2,  exp_err: 1'b1, exp_done: 0};
        vecs[4] = '{n: 8'd0,  steps: 0, fin: 8'd2,  exp_err: 1'b1, exp_done: 0};
        vecs[5] = '{n: 8'd3,  steps: 1, fin: 8'd3,  exp_err: 1'b0, exp_done: 1};
        vecs[6] = '{n: 8'd3,  steps: 0, fin: 8'd3,  exp_err: 1'b0, exp_done: 1};
        vecs[7] = '{n: 8'd8,  steps: 5, fin: 8'd8,  exp_err: 1'b0, exp_done: 1};
        vecs[8] = '{n: 8'd8,  steps: 0, fin: 8'd8,  exp_err: 1'b0, exp_done: 1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_n     = '0;
        abort     = 1'b0;
        tc_force  = 1'b0;
        tc_auto   = 1'b1;

        // Reset values
        @(negedge clk_out);
        @(negedge clk_out);
        check("rst_div_n", div_n, 8);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_load", div_load, 0);
        rst_n = 1'b1;
        @(negedge clk_out);

        for (int i = 0; i < 9; i++) run_req(vecs[i], i);

        // Abort during the first SETTLE of an 8 -> 12 ramp
        wait_ready("ab_ready");
        req_n     = 8'd12;
        req_valid = 1'b1;
        @(negedge clk_out);
        req_valid = 1'b0;
        w = 0;
        while (div_load !== 1'b1 && w < 100) begin
            @(negedge clk_out);
            w++;
        end
        check("ab_load_seen", div_load, 1);
        check("ab_load_n", div_n, 9);
        abort = 1'b1;
        @(negedge clk_out);
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_ready_after", req_ready, 1);
        check("ab_div_n", div_n, 9);
        check("ab_done", done, 0);
        nload = 0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_out);
            if (div_load === 1'b1) nload++;
            if (done === 1'b1) ndone++;
        end
        check("ab_no_load", nload, 0);
        check("ab_no_done", ndone, 0);
        check("ab_hold_n", div_n, 9);

        // Requests while busy are ignored: 9 -> 10 with a stray 20 request
        wait_ready("bz_ready");
        req_n     = 8'd10;
        req_valid = 1'b1;
        @(negedge clk_out);
        req_n = 8'd20;
        check("bz_ready_low", req_ready, 0);
        ndone = 0;
        nload = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) @(negedge clk_out);
            if (c == 3) req_valid = 1'b0;
            if (div_load === 1'b1) nload++;
            if (done === 1'b1) begin
                ndone++;
                break;
            end
        end
        req_valid = 1'b0;
        check("bz_done", ndone, 1);
        check("bz_loads", nload, 1);
        check("bz_div_n", div_n, 10);
        @(negedge clk_out);
        @(negedge clk_out);
        check("bz_idle_after", busy, 0);
        check("bz_n_after", div_n, 10);

        // abort together with div_tc in WAIT_TC: no step
        tc_auto = 1'b0;
        @(negedge clk_out);
        @(negedge clk_out);
        wait_ready("at_ready");
        req_n     = 8'd11;
        req_valid = 1'b1;
        @(negedge clk_out);
        req_valid = 1'b0;
        check("at_busy", busy, 1);
        tc_force = 1'b1;
        abort    = 1'b1;
        @(negedge clk_out);
        tc_force = 1'b0;
        abort    = 1'b0;
        check("at_no_load", div_load, 0);
        check("at_div_n", div_n, 10);
        check("at_idle", busy, 0);
        check("at_no_done", done, 0);
        tc_auto = 1'b1;
        @(negedge clk_out);
        check("at_hold_n", div_n, 10);

        // Reset mid-ramp: 8 -> 20, reset once div_n reaches 10
        hv = '{n: 8'd8, steps: 2, fin: 8'd8, exp_err: 1'b0, exp_done: 1};
        run_req(hv, 20);
        wait_ready("rs_ready");
        req_n     = 8'd20;
        req_valid = 1'b1;
        @(negedge clk_out);
        req_valid = 1'b0;
        w = 0;
        while (div_n !== 8'd10 && w < 200) begin
            @(negedge clk_out);
            w++;
        end
        check("rs_reached_10", div_n, 10);
        check("rs_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_async_div_n", div_n, 8);
        check("rs_async_busy", busy, 0);
        check("rs_async_ready", req_ready, 1);
        check("rs_async_load", div_load, 0);
        check("rs_async_done", done, 0);
        check("rs_async_err", err, 0);
        @(negedge clk_out);
        rst_n = 1'b1;
        @(negedge clk_out);
        hv = '{n: 8'd9, steps: 1, fin: 8'd9, exp_err: 1'b0, exp_done: 1};
        run_req(hv, 21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
